// File: rtl/run_serializer_pkg.sv
// Shared types and constants for the run-length serializer.
package run_serializer_pkg;

    // Line run counter saturation point; run4 fires when it is reached.
    localparam int unsigned RUN_SAT   = 4;
    // Widest run-length field the descriptor struct can carry.
    localparam int unsigned LEN_W_MAX = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Queued run descriptor; len is zero-extended from the block's LEN_W.
    typedef struct packed {
        logic                 bit_val;
        logic [LEN_W_MAX-1:0] len;
    } desc_t;

endpackage

// File: rtl/run_serializer_if.sv
// Descriptor handshake between a producer and the run serializer.
interface run_serializer_if #(
    parameter int unsigned LEN_W = 4
);
    logic             desc_valid;
    logic             desc_ready;
    logic             desc_bit;
    logic [LEN_W-1:0] desc_len;

    modport master (
        output desc_valid,
        output desc_bit,
        output desc_len,
        input  desc_ready
    );

    modport slave (
        input  desc_valid,
        input  desc_bit,
        input  desc_len,
        output desc_ready
    );
endinterface

// File: rtl/run_serializer_desc_fifo.sv
// Small synchronous FIFO holding pending run descriptors (first-word fall-through).
module desc_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  T                 wdata,
    output T                 rdata_c,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_n;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata_c = mem[rd_ptr];

    // Next occupancy from this cycle's push/pop.
    always_comb begin
        count_n = count + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_n;
            full  <= (count_n == CNT_W'(DEPTH));
            empty <= (count_n == '0);
        end
    end

    // Storage write; contents are don't-care while empty so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/run_serializer.sv
// Serial run-length transmitter: descriptors in, one line bit per cycle out,
// with run4 flagging the 4th-or-later equal bit on the line.
module run_serializer
    import run_serializer_pkg::*;
#(
    parameter int unsigned LEN_W = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    run_serializer_if.slave desc,
    output logic            ser_out,
    output logic            ser_valid,
    output logic            run4,
    output logic            busy
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned RUN_W = 3;

    state_t           state;
    state_t           state_n;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_n;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_cnt_n;
    logic             ser_out_n;
    logic             ser_valid_n;
    logic             run4_n;
    logic             busy_n;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] occ_n;
    desc_t            wdata;
    desc_t            head;

    // Zero-length descriptors are always taken and simply never written.
    assign desc.desc_ready = !fifo_full || (desc.desc_len == '0);
    assign push  = desc.desc_valid && desc.desc_ready && (desc.desc_len != '0);
    assign wdata = '{bit_val: desc.desc_bit, len: LEN_W_MAX'(desc.desc_len)};

    desc_fifo #(
        .T     (desc_t),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wdata   (wdata),
        .rdata_c (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Next state, line value, run tracking and busy.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        ser_out_n   = 1'b0;
        ser_valid_n = 1'b0;
        pop         = 1'b0;

        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    ser_out_n   = head.bit_val;
                    ser_valid_n = 1'b1;
                    cnt_n       = LEN_W'(head.len - LEN_W_MAX'(1));
                    state_n     = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt != '0) begin
                    ser_out_n   = ser_out;
                    ser_valid_n = 1'b1;
                    cnt_n       = cnt - LEN_W'(1);
                end else if (!fifo_empty) begin
                    // Chain straight into the next run with no idle bubble.
                    pop         = 1'b1;
                    ser_out_n   = head.bit_val;
                    ser_valid_n = 1'b1;
                    cnt_n       = LEN_W'(head.len - LEN_W_MAX'(1));
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Idle drives 0, so the counter follows the line every cycle.
        if (ser_out_n == ser_out) begin
            run_cnt_n = (run_cnt == RUN_W'(RUN_SAT)) ? run_cnt : run_cnt + RUN_W'(1);
        end else begin
            run_cnt_n = RUN_W'(1);
        end
        run4_n = (run_cnt_n == RUN_W'(RUN_SAT));

        occ_n  = fifo_count + CNT_W'(push) - CNT_W'(pop);
        busy_n = ser_valid_n || (occ_n != '0);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            run_cnt   <= RUN_W'(1);
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            run4      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            run_cnt   <= run_cnt_n;
            ser_out   <= ser_out_n;
            ser_valid <= ser_valid_n;
            run4      <= run4_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_run_serializer.sv
// Directed scoreboard bench for run_serializer.
module tb_run_serializer;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic b;
        logic r4;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic ser_out;
    logic ser_valid;
    logic run4;
    logic busy;

    run_serializer_if #(.LEN_W(LEN_W)) intf ();

    run_serializer #(
        .LEN_W (LEN_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .desc      (intf),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .run4      (run4),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int   checks     = 0;
    int   failures   = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic mdl_last   = 1'b0;
    int   mdl_cnt    = 4;
    bit   mon_en     = 1'b0;
    int   burst_cnt  = 0;
    int   last_burst = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference line model: expected bit and run4 for every emitted cycle.
    task automatic exp_run(input logic b, input int len, input bit contiguous);
        if (!contiguous) begin
            mdl_last = 1'b0;
            mdl_cnt  = 4;
        end
        for (int i = 0; i < len; i++) begin
            if (b == mdl_last) mdl_cnt = (mdl_cnt >= 4) ? 4 : mdl_cnt + 1;
            else               mdl_cnt = 1;
            mdl_last = b;
            exp_q.push_back('{b: b, r4: (mdl_cnt == 4)});
        end
    endtask

    task automatic push_desc(input logic b, input logic [LEN_W-1:0] l);
        int guard = 0;
        intf.desc_valid = 1'b1;
        intf.desc_bit   = b;
        intf.desc_len   = l;
        #1;
        while (intf.desc_ready !== 1'b1 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("push_accepted", 32'(guard < 50), 1);
        @(posedge clk);
        #1;
        intf.desc_valid = 1'b0;
    endtask

    task automatic send(input logic b, input int len, input bit contiguous);
        exp_run(b, len, contiguous);
        push_desc(b, LEN_W'(len));
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || ser_valid !== 1'b0 || busy !== 1'b0) && guard < 200) begin
            step(1);
            guard++;
        end
        chk("drain", 32'(exp_q.size() == 0 && ser_valid === 1'b0 && busy === 1'b0), 1);
        @(negedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard on every valid line cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ser_valid === 1'b1) begin
                burst_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_bit", 32'(ser_valid), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ser_out", 32'(ser_out), 32'(mon_e.b));
                    chk("run4", 32'(run4), 32'(mon_e.r4));
                end
            end else begin
                chk("idle_line", 32'(ser_out), 0);
                if (burst_cnt != 0) begin
                    last_burst = burst_cnt;
                    burst_cnt  = 0;
                end
            end
        end else begin
            burst_cnt = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        intf.desc_valid = 1'b0;
        intf.desc_bit   = 1'b0;
        intf.desc_len   = LEN_W'(1);

        // Reset values, then idle zeros drive run4 in the 4th cycle.
        step(2);
        chk("rst_ser_out", 32'(ser_out), 0);
        chk("rst_ser_valid", 32'(ser_valid), 0);
        chk("rst_run4", 32'(run4), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(intf.desc_ready), 1);
        reset  = 1'b0;
        mon_en = 1'b1;
        step(2);
        chk("idle_run4_c3", 32'(run4), 0);
        step(1);
        chk("idle_run4_c4", 32'(run4), 1);
        chk("idle_busy", 32'(busy), 0);
        step(3);

        // Single run {1,5}: latency, run4 on bits 4-5, clean end.
        send(1'b1, 5, 1'b0);
        chk("lat_t", 32'(ser_valid), 0);
        step(1);
        chk("lat_t1_valid", 32'(ser_valid), 1);
        chk("lat_t1_bit", 32'(ser_out), 1);
        step(4);
        chk("run5_run4", 32'(run4), 1);
        step(1);
        chk("run5_end_valid", 32'(ser_valid), 0);
        chk("run5_end_run4", 32'(run4), 0);
        drain();
        chk("run5_len", 32'(last_burst), 5);
        step(4);

        // {1,1} then {0,2},{0,2}: zeros join into one run of four.
        send(1'b1, 1, 1'b0);
        send(1'b0, 2, 1'b1);
        send(1'b0, 2, 1'b1);
        drain();
        chk("join_len", 32'(last_burst), 5);
        step(4);

        // {1,3},{0,3},{1,1}: FIFO fills, zero-length still accepted while full.
        send(1'b1, 3, 1'b0);
        send(1'b0, 3, 1'b1);
        send(1'b1, 1, 1'b1);
        chk("full_ready", 32'(intf.desc_ready), 0);
        chk("full_busy", 32'(busy), 1);
        intf.desc_valid = 1'b1;
        intf.desc_len   = '0;
        #1;
        chk("zero_len_ready_full", 32'(intf.desc_ready), 1);
        @(posedge clk);
        #1;
        intf.desc_valid = 1'b0;
        intf.desc_len   = LEN_W'(1);
        drain();
        chk("three_len", 32'(last_burst), 7);
        chk("three_ready", 32'(intf.desc_ready), 1);
        step(4);

        // Zero-length descriptor in idle: nothing emitted, never busy.
        send(1'b1, 0, 1'b0);
        chk("zero_busy0", 32'(busy), 0);
        step(5);
        chk("zero_busy5", 32'(busy), 0);
        chk("zero_valid", 32'(ser_valid), 0);

        // Async reset in the middle of {1,7}.
        mon_en = 1'b0;
        push_desc(1'b1, LEN_W'(7));
        step(3);
        chk("mid_valid", 32'(ser_valid), 1);
        chk("mid_bit", 32'(ser_out), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_ser_out", 32'(ser_out), 0);
        chk("arst_ser_valid", 32'(ser_valid), 0);
        chk("arst_run4", 32'(run4), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(intf.desc_ready), 1);
        step(1);
        reset      = 1'b0;
        last_burst = 0;
        mon_en     = 1'b1;
        step(2);
        chk("post_run4_c3", 32'(run4), 0);
        step(1);
        chk("post_run4_c4", 32'(run4), 1);
        step(10);
        chk("post_busy", 32'(busy), 0);
        chk("post_residual", 32'(last_burst), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/run_serializer.md
# run_serializer

Serial run-length transmitter that turns a queue of run descriptors (bit value, run length) into a one-bit-per-cycle line. It is the producer end of the consecutive-bit pattern path: its `ser_out` drives the `in` input of the four-in-a-row sequence detector. It also raises `run4` in the cycle the line carries the 4th or later equal bit, so the detector's `out` is predicted exactly one cycle ahead.

## Interface
- `LEN_W`, default 4: width of the run-length field; max run is 2^LEN_W − 1 bits.
- `DEPTH`, default 2: descriptor FIFO entries, power of two, ≥ 2.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `desc_valid`, in, 1: descriptor offered.
- `desc_ready`, out, 1: descriptor accepted when `desc_valid && desc_ready`.
- `desc_bit`, in, 1: bit value of the run.
- `desc_len`, in, LEN_W: run length in cycles.
- `ser_out`, out, 1: serial line; 0 when no run is active.
- `ser_valid`, out, 1: `ser_out` carries a descriptor bit this cycle.
- `run4`, out, 1: current `ser_out` is ≥ 4th consecutive equal value on the line.
- `busy`, out, 1: FIFO non-empty or a run in progress.

## Operation
- Reset values: `ser_out`=0, `ser_valid`=0, `run4`=0, `busy`=0, `desc_ready`=1, FIFO empty, remaining count 0, line run counter 1.
- `desc_ready` = FIFO not full, or `desc_len`==0. Zero-length descriptors are accepted and dropped, never written.
- FSM states: IDLE, SHIFT.
  - IDLE: if FIFO non-empty, pop head; load `cur_bit`, `cnt`=len−1; drive `ser_out`=bit, `ser_valid`=1; go SHIFT.
  - SHIFT, `cnt`≠0: drive `ser_out`=`cur_bit`, `ser_valid`=1, `cnt`−1.
  - SHIFT, `cnt`=0, FIFO non-empty: pop and load next descriptor on that edge. There is no bubble between runs.
  - SHIFT, `cnt`=0, FIFO empty: `ser_out`=0, `ser_valid`=0; go IDLE.
- Line run counter (3 bits, saturating at 4) tracks every cycle, idle cycles included, because idle drives 0.
  - Next `ser_out` equals current: counter +1, saturating.
  - Otherwise: counter reloads to 1.
  - `run4` is registered: 1 when the next counter value is 4.
- Two adjacent descriptors with the same bit form one continuous run for `run4`.
- Push on a full FIFO is impossible (`ready` low). Pop and push in the same cycle are legal when not full.
- Asynchronous reset mid-run clears FIFO, counters and outputs at once. Queued and in-flight descriptors are lost.

## Timing
- All outputs are registered.
- A descriptor accepted at edge t into an empty, idle block: first bit visible after edge t+1; L bits on `ser_out` during cycles t+1 … t+L.
- Back-to-back runs are contiguous.
- `run4` in cycle k predicts detector `out` in cycle k+1.
- After reset, the idle line counts as zeros: `run4` rises in the 4th cycle after reset release.
- `desc_ready` reflects the FIFO count after the previous edge. There is no combinational path from `desc_valid` to `desc_ready`.

## Structure
- Shared package holds:
  - the state typedef (IDLE, SHIFT);
  - `RUN_SAT`=4;
  - the descriptor struct {bit, len[LEN_W]}.
- One sub-module, `desc_fifo`: a synchronous DEPTH-entry FIFO with push/pop, full/empty and asynchronous reset.
- The FSM, remaining counter and line run counter live in `run_serializer`.

## Test plan
- Reset release, no descriptors → `ser_valid`=0 and `ser_out`=0 throughout; `run4`=1 from the 4th cycle on; `busy`=0.
- Single {1,5} → `ser_out`=1 for exactly 5 cycles starting at t+1; `run4`=1 on bits 4–5; `run4`=0 the cycle after; `ser_valid` drops after the 5th bit.
- {0,2} then {0,2} back-to-back → 4 contiguous zeros with no gap; `run4` high on the 4th bit.
- {1,3},{0,3},{1,1} queued with downstream held idle → FIFO fills and `desc_ready`=0 when DEPTH is reached; output 111 000 1 contiguous; `run4` never high during the runs.
- {1,0} offered → accepted in one cycle; nothing emitted; `busy` stays 0.
- Async `reset` asserted mid-way through {1,7} → outputs go to 0 immediately without a clock edge; after release the FIFO is empty and no residual bits appear.
